// File: rtl/gpio_irq_controller.sv
// Multi-port GPIO controller: per-pin direction, atomic set/clear, synchronised
// inputs, per-pin rise/fall edge interrupts with W1C status and registered reads.

module gpio_port #(
   parameter int PIN_AMOUNT  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PIN_AMOUNT-1:0] pad,
   input  logic                  wr_en,
   input  logic [2:0]            wr_idx,
   input  logic [PIN_AMOUNT-1:0] wdata,
   input  logic [2:0]            rd_idx,
   output logic [PIN_AMOUNT-1:0] rdata,
   output logic [PIN_AMOUNT-1:0] out_val,
   output logic [PIN_AMOUNT-1:0] dir_val,
   output logic                  irq
);
   logic [SYNC_STAGES-1:0][PIN_AMOUNT-1:0] sync_q;
   logic [PIN_AMOUNT-1:0] out_q, dir_q, rise_en_q, fall_en_q, stat_q, prev_q;
   logic [PIN_AMOUNT-1:0] pin, rise, fall, w1c;

   // Inputs follow the pad; outputs loop back their own drive value.
   assign pin  = (dir_q & sync_q[SYNC_STAGES-1]) | (~dir_q & out_q);
   assign rise = pin & ~prev_q;
   assign fall = ~pin & prev_q;
   assign w1c  = (wr_en && wr_idx == 3'd7) ? wdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= '0;
         out_q     <= '0;
         dir_q     <= '1;
         rise_en_q <= '0;
         fall_en_q <= '0;
         stat_q    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
         prev_q <= pin;
         // A fresh edge beats a same-cycle clear of that bit.
         stat_q <= (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
         if (wr_en) begin
            case (wr_idx)
               3'd0:    out_q     <= wdata;
               3'd1:    dir_q     <= wdata;
               3'd3:    out_q     <= out_q | wdata;
               3'd4:    out_q     <= out_q & ~wdata;
               3'd5:    rise_en_q <= wdata;
               3'd6:    fall_en_q <= wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (rd_idx)
         3'd0, 3'd3, 3'd4: rdata = out_q;
         3'd1:             rdata = dir_q;
         3'd2:             rdata = pin;
         3'd5:             rdata = rise_en_q;
         3'd6:             rdata = fall_en_q;
         3'd7:             rdata = stat_q;
         default:          rdata = '0;
      endcase
   end

   assign out_val = out_q;
   assign dir_val = dir_q;
   assign irq     = |stat_q;
endmodule

module gpio_irq_controller #(
   parameter int PORT_AMOUNT          = 2,
   parameter int PIN_AMOUNT           = 8,
   parameter int ADDR_INTERFACE_WIDTH = 64,
   parameter int SYNC_STAGES          = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [ADDR_INTERFACE_WIDTH-1:0]         raddr_PORT,
   input  logic                                    rd_req,
   output logic [PIN_AMOUNT-1:0]                   rdata_PORT,
   output logic                                    rd_valid,
   output logic                                    rd_available,
   input  logic [ADDR_INTERFACE_WIDTH-1:0]         waddr_PORT,
   input  logic [PIN_AMOUNT-1:0]                   wdata_PORT,
   input  logic                                    wr_req,
   output logic                                    wr_available,
   input  logic [PORT_AMOUNT-1:0][PIN_AMOUNT-1:0]  PORT_i,
   output logic [PORT_AMOUNT-1:0][PIN_AMOUNT-1:0]  PORT_o,
   output logic [PORT_AMOUNT-1:0][PIN_AMOUNT-1:0]  PORT_oe,
   output logic                                    irq
);
   localparam int APW = (PORT_AMOUNT > 1) ? $clog2(PORT_AMOUNT) : 1;
   localparam logic [APW:0] PORT_LIM = (APW+1)'(PORT_AMOUNT);
   localparam int RD_STAGES = 1;

   typedef struct packed {
      logic [APW-1:0] port;
      logic [2:0]     idx;
   } addr_dec_t;

   addr_dec_t rdec, wdec;
   logic      unused_addr_bits;

   assign rdec = raddr_PORT[APW+2:0];
   assign wdec = waddr_PORT[APW+2:0];
   assign unused_addr_bits = ^{raddr_PORT[ADDR_INTERFACE_WIDTH-1:APW+3],
                               waddr_PORT[ADDR_INTERFACE_WIDTH-1:APW+3]};

   assign rd_available = ({1'b0, rdec.port} < PORT_LIM);
   assign wr_available = ({1'b0, wdec.port} < PORT_LIM);

   logic [PORT_AMOUNT-1:0][PIN_AMOUNT-1:0] port_rdata, port_dir;
   logic [PORT_AMOUNT-1:0]                 port_irq;

   for (genvar p = 0; p < PORT_AMOUNT; p++) begin : g_port
      gpio_port #(
         .PIN_AMOUNT  (PIN_AMOUNT),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_port (
         .clk     (clk),
         .rst_n   (rst_n),
         .pad     (PORT_i[p]),
         .wr_en   (wr_req && wr_available && wdec.port == APW'(p)),
         .wr_idx  (wdec.idx),
         .wdata   (wdata_PORT),
         .rd_idx  (rdec.idx),
         .rdata   (port_rdata[p]),
         .out_val (PORT_o[p]),
         .dir_val (port_dir[p]),
         .irq     (port_irq[p])
      );
      assign PORT_oe[p] = ~port_dir[p];
   end

   assign irq = |port_irq;

   // Invalid ports fall through to zero but still produce a valid pulse.
   logic [PIN_AMOUNT-1:0] rdata_d;
   always_comb begin
      rdata_d = '0;
      for (int p = 0; p < PORT_AMOUNT; p++)
         if (rd_available && rdec.port == APW'(p)) rdata_d = port_rdata[p];
   end

   logic [RD_STAGES:1] vld_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe   <= '0;
         rdata_PORT <= '0;
      end else begin
         vld_pipe[1] <= rd_req;
         if (rd_req) rdata_PORT <= rdata_d;
      end
   end

   assign rd_valid = vld_pipe[RD_STAGES];
endmodule
